// File: rtl/timer_pkg.sv
// Shared types and register map for the memory-mapped machine timer.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } tmr_state_e;

   localparam logic [2:0] MTIME_LO    = 3'd0;
   localparam logic [2:0] MTIME_HI    = 3'd1;
   localparam logic [2:0] MTIMECMP_LO = 3'd2;
   localparam logic [2:0] MTIMECMP_HI = 3'd3;
   localparam logic [2:0] CTRL        = 3'd4;
   localparam int         CTRL_EN_BIT = 0;

   // Byte-lane merge of store data into an existing 32-bit word.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  lanes);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) begin
            res[8*i +: 8] = new_v[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_v[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mmio_timer_responder_if.sv
// Data-memory request bus between the core (master) and the timer (slave).
interface mmio_timer_responder_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  mask;
   logic        cs;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] rdata;
   logic        stall;

   modport master (output addr, wdata, mask, cs, rd_en, wr_en,
                   input  rdata, stall);
   modport slave  (input  addr, wdata, mask, cs, rd_en, wr_en,
                   output rdata, stall);
endinterface

// File: rtl/timer_prescaler.sv
// Divides clk by PRESCALE to produce a one-cycle mtime tick while enabled.
module timer_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clear_i,
   output logic tick_o
);

   localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = en_i & (cnt_q == LAST);

   // Count is forced to zero while disabled or when software rewrites mtime.
   always_comb begin
      cnt_d = cnt_q;
      if (!en_i || clear_i || tick_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mmio_timer_responder.sv
// Machine-timer peripheral on the MW-stage data bus: mtime, mtimecmp, ctrl,
// a wait-stated IDLE/BUSY/RESP handshake, and a level timer interrupt.
module mmio_timer_responder
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_4000,
   parameter int          WAIT_STATES = 1,
   parameter int          PRESCALE    = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   mmio_timer_responder_if.slave  bus,
   output logic                   timer_intrpt
);

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   tmr_state_e  state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic        hit_q, we_q, en_q, irq_q;
   logic [2:0]  idx_q;
   logic [31:0] wdata_q, rdata_q, rd_val_s;
   logic [3:0]  mask_q;
   logic [63:0] mtime_q, mtime_d, mtcmp_q, mtcmp_d;
   logic        en_d, irq_d;
   logic [31:0] rdata_d;
   logic        req_s, hit_s, stall_s, latch_s, commit_s;
   logic        wr_s, mtime_wr_s, tick_s;
   logic        unused_s;

   assign req_s    = ~bus.cs & (bus.rd_en | bus.wr_en);
   assign hit_s    = (bus.addr[31:5] == BASE_ADDR[31:5]);
   assign unused_s = ^bus.addr[1:0];

   // Handshake FSM: next state, wait counter and strobes.
   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      stall_s  = 1'b0;
      latch_s  = 1'b0;
      commit_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_s) begin
               stall_s = 1'b1;
               latch_s = 1'b1;
               wcnt_d  = WAIT_LOAD;
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            stall_s = 1'b1;
            if (wcnt_q == 4'd0) begin
               commit_s = 1'b1;
               state_d  = RESP;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Gate with rst so stall drops the moment reset is asserted.
   assign bus.stall    = stall_s & ~rst;
   assign bus.rdata    = rdata_q;
   assign timer_intrpt = irq_q;

   assign wr_s       = commit_s & we_q & hit_q;
   assign mtime_wr_s = wr_s & (|mask_q) & ((idx_q == MTIME_LO) | (idx_q == MTIME_HI));

   timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en_q),
      .clear_i (mtime_wr_s),
      .tick_o  (tick_s)
   );

   // Register read mux for the latched index.
   always_comb begin
      rd_val_s = 32'd0;
      if (hit_q) begin
         case (idx_q)
            MTIME_LO:    rd_val_s = mtime_q[31:0];
            MTIME_HI:    rd_val_s = mtime_q[63:32];
            MTIMECMP_LO: rd_val_s = mtcmp_q[31:0];
            MTIMECMP_HI: rd_val_s = mtcmp_q[63:32];
            CTRL:        rd_val_s = {31'd0, en_q};
            default:     rd_val_s = 32'd0;
         endcase
      end else begin
         rd_val_s = 32'd0;
      end
   end

   // Register file update; a software write to mtime overrides a same-cycle tick.
   always_comb begin
      mtime_d = mtime_q;
      mtcmp_d = mtcmp_q;
      en_d    = en_q;
      if (wr_s && idx_q == MTIME_LO) begin
         mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wdata_q, mask_q)};
      end else if (wr_s && idx_q == MTIME_HI) begin
         mtime_d = {merge_bytes(mtime_q[63:32], wdata_q, mask_q), mtime_q[31:0]};
      end else if (tick_s) begin
         mtime_d = mtime_q + 64'd1;
      end else begin
         mtime_d = mtime_q;
      end
      if (wr_s && idx_q == MTIMECMP_LO) begin
         mtcmp_d = {mtcmp_q[63:32], merge_bytes(mtcmp_q[31:0], wdata_q, mask_q)};
      end else if (wr_s && idx_q == MTIMECMP_HI) begin
         mtcmp_d = {merge_bytes(mtcmp_q[63:32], wdata_q, mask_q), mtcmp_q[31:0]};
      end else begin
         mtcmp_d = mtcmp_q;
      end
      if (wr_s && idx_q == CTRL && mask_q[0]) begin
         en_d = wdata_q[CTRL_EN_BIT];
      end else begin
         en_d = en_q;
      end
      irq_d   = en_q & (mtime_q >= mtcmp_q);
      rdata_d = (commit_s && !we_q) ? rd_val_s : rdata_q;
   end

   // State and register storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wcnt_q  <= 4'd0;
         hit_q   <= 1'b0;
         we_q    <= 1'b0;
         idx_q   <= 3'd0;
         wdata_q <= 32'd0;
         mask_q  <= 4'd0;
         mtime_q <= 64'd0;
         mtcmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
         en_q    <= 1'b0;
         irq_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         if (latch_s) begin
            hit_q   <= hit_s;
            we_q    <= bus.wr_en;
            idx_q   <= bus.addr[4:2];
            wdata_q <= bus.wdata;
            mask_q  <= bus.mask;
         end else begin
            hit_q   <= hit_q;
            we_q    <= we_q;
            idx_q   <= idx_q;
            wdata_q <= wdata_q;
            mask_q  <= mask_q;
         end
         mtime_q <= mtime_d;
         mtcmp_q <= mtcmp_d;
         en_q    <= en_d;
         irq_q   <= irq_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Directed and randomized bench for mmio_timer_responder against a time-based mtime model.
module tb_mmio_timer_responder;

   localparam int          WS   = 1;
   localparam int          P    = 4;
   localparam logic [31:0] BASE = 32'h0000_4000;

   logic clk = 1'b0;
   logic rst;
   logic irq;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   mmio_timer_responder_if bus ();

   mmio_timer_responder #(.BASE_ADDR(BASE), .WAIT_STATES(WS), .PRESCALE(P)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .timer_intrpt (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Model: mtime is a linear function of the edge count since the last anchor.
   logic [31:0] cmp_lo, cmp_hi;
   logic [63:0] m_base;
   int          m_e;
   bit          m_en;

   function automatic logic [63:0] mt(input int t);
      if (!m_en || t < m_e) return m_base;
      return m_base + 64'((t - m_e) / P);
   endfunction

   function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d, input logic [3:0] m);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   task automatic model_reset();
      cmp_lo = 32'hFFFF_FFFF; cmp_hi = 32'hFFFF_FFFF;
      m_base = 64'd0; m_e = 0; m_en = 1'b0;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Commit edge r: write applied at r, so mtime before the write is mt(r-1).
   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input int r);
      logic [63:0] old;
      if (a[31:5] != BASE[31:5]) return;
      case (a[4:2])
         3'd0: if (m != 4'd0) begin old = mt(r - 1); m_base = {old[63:32], mrg(old[31:0], d, m)}; m_e = r; end
         3'd1: if (m != 4'd0) begin old = mt(r - 1); m_base = {mrg(old[63:32], d, m), old[31:0]}; m_e = r; end
         3'd2: cmp_lo = mrg(cmp_lo, d, m);
         3'd3: cmp_hi = mrg(cmp_hi, d, m);
         3'd4: if (m[0] && d[0] != m_en) begin m_base = mt(r); m_e = r; m_en = d[0]; end
         default: ;
      endcase
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a, input int r);
      logic [63:0] v;
      v = mt(r - 1);
      if (a[31:5] != BASE[31:5]) return 32'd0;
      case (a[4:2])
         3'd0: return v[31:0];
         3'd1: return v[63:32];
         3'd2: return cmp_lo;
         3'd3: return cmp_hi;
         3'd4: return {31'd0, m_en};
         default: return 32'd0;
      endcase
   endfunction

   // Called just after a rising edge; returns in IDLE just after a rising edge.
   task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, output logic [31:0] rd, output int r);
      int n;
      n = 0; r = -1;
      bus.addr = a; bus.wdata = d; bus.mask = m;
      bus.cs = 1'b0; bus.rd_en = ~we; bus.wr_en = we;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.stall) n++;
         else begin r = cyc; break; end
      end
      rd = bus.rdata;
      bus.cs = 1'b1; bus.rd_en = 1'b0; bus.wr_en = 1'b0;
      check("latency", 64'(n), 64'(WS + 2));
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      logic [31:0] rd; int r;
      access(1'b1, a, d, m, rd, r);
      model_write(a, d, m, r);
   endtask

   task automatic rdc(input string tag, input logic [31:0] a, output logic [31:0] rd);
      int r;
      access(1'b0, a, 32'd0, 4'd0, rd, r);
      check(tag, 64'(rd), 64'(model_read(a, r)));
   endtask

   initial begin
      logic [31:0] rv;
      int seen;
      bus.cs = 1'b1; bus.rd_en = 1'b0; bus.wr_en = 1'b0;
      bus.addr = 32'd0; bus.wdata = 32'd0; bus.mask = 4'd0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", 64'(bus.stall), 64'd0);
      check("rst_irq", 64'(irq), 64'd0);
      check("rst_rdata", 64'(bus.rdata), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Two back-to-back reads of ctrl with the request held throughout.
      bus.addr = BASE + 32'd16; bus.cs = 1'b0; bus.rd_en = 1'b1; bus.wr_en = 1'b0;
      for (int i = 0; i < 2 * (WS + 3); i++) begin
         @(negedge clk);
         check("b2b_stall", 64'(bus.stall), 64'((i % (WS + 3)) != (WS + 2)));
         if ((i % (WS + 3)) == (WS + 2)) check("b2b_rdata", 64'(bus.rdata), 64'd0);
      end
      bus.cs = 1'b1; bus.rd_en = 1'b0;
      @(posedge clk); #1;

      wr(BASE + 32'd8, 32'hAABB_CCDD, 4'b0101);
      rdc("mask_model", BASE + 32'd8, rv);
      check("mask_const", 64'(rv), 64'h0000_0000_FFBB_FFDD);

      for (int i = 0; i < 30; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 7) == 0) ? BASE + 32'(32 * $urandom_range(1, 3)) : BASE;
         a = a + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) wr(a, $urandom, 4'($urandom_range(0, 15)));
         else rdc("rand_rd", a, rv);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      wr(BASE + 32'd32, 32'h5A5A_5A5A, 4'hF);
      wr(BASE + 32'd40, 32'h5A5A_5A5A, 4'hF);
      rdc("miss_cmp_lo", BASE + 32'd8, rv);
      rdc("miss_cmp_hi", BASE + 32'd12, rv);
      rdc("miss_rd", BASE + 32'd32, rv);
      rdc("idx5_rd", BASE + 32'd20, rv);

      // Reset while the write to mtimecmp_lo is in BUSY.
      bus.addr = BASE + 32'd8; bus.wdata = 32'h1234_5678; bus.mask = 4'hF;
      bus.cs = 1'b0; bus.wr_en = 1'b1; bus.rd_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_stall", 64'(bus.stall), 64'd0);
      bus.cs = 1'b1; bus.wr_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      @(posedge clk); #1;
      rdc("rst_lost_model", BASE + 32'd8, rv);
      check("rst_lost_const", 64'(rv), 64'h0000_0000_FFFF_FFFF);

      wr(BASE + 32'd0, 32'hFFFF_FFFE, 4'hF);
      wr(BASE + 32'd4, 32'hFFFF_FFFF, 4'hF);
      wr(BASE + 32'd16, 32'd1, 4'h1);
      while (cyc + 2 + WS - 1 - m_e < 8) begin @(posedge clk); #1; end
      rdc("wrap_lo", BASE + 32'd0, rv);
      check("wrap_zero", 64'(rv), 64'd0);
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 6)) @(posedge clk);
         #1;
         rdc("count_lo", BASE + 32'd0, rv);
         rdc("count_hi", BASE + 32'd4, rv);
      end

      // Align the mtime_lo commit with a tick edge.
      while (((cyc + 2 + WS - m_e) % P) != 0) begin @(posedge clk); #1; end
      wr(BASE + 32'd0, 32'h0000_1234, 4'hF);
      rdc("collide_lo", BASE + 32'd0, rv);
      check("collide_exact", 64'(rv), 64'h0000_0000_0000_1234);

      wr(BASE + 32'd16, 32'd0, 4'h1);
      wr(BASE + 32'd0, 32'd0, 4'hF);
      wr(BASE + 32'd4, 32'd0, 4'hF);
      wr(BASE + 32'd12, 32'd0, 4'hF);
      wr(BASE + 32'd8, 32'd10, 4'hF);
      check("irq_low_pre", 64'(irq), 64'd0);
      wr(BASE + 32'd16, 32'd1, 4'h1);
      seen = 0;
      for (int i = 0; i < 60 && seen < 3; i++) begin
         @(negedge clk);
         check("irq_track", 64'(irq), 64'(mt(cyc - 1) >= {cmp_hi, cmp_lo}));
         if (irq) seen++;
      end
      check("irq_rose", 64'(seen), 64'd3);
      @(posedge clk); #1;
      wr(BASE + 32'd12, 32'd1, 4'hF);
      check("irq_drop_cmp", 64'(irq), 64'd0);
      wr(BASE + 32'd12, 32'd0, 4'hF);
      check("irq_again", 64'(irq), 64'd1);
      wr(BASE + 32'd16, 32'd0, 4'h1);
      check("irq_drop_en", 64'(irq), 64'd0);
      rdc("frozen_a", BASE + 32'd0, rv);
      repeat (10) @(posedge clk);
      #1;
      rdc("frozen_b", BASE + 32'd0, rv);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
